// File: rtl/seq_alu_multicycle.sv
// seq_alu_multicycle
//   Registered ALU with single-cycle ADD/SUB/AND/OR/XOR/SLTU and
//   multi-cycle unsigned MUL (shift-add) and DIV (restoring), one bit per clock.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   start   request, accepted only while idle
//   op      operation code, captured at accept
//   a, b    unsigned operands, captured at accept
//   result  registered 2*WIDTH-bit result, held until the next completion
//   done    one-cycle completion pulse
//   busy    high while MUL/DIV iterates
//   zero    registered result == 0
//   carry   ADD carry-out / SUB borrow, 0 for other ops
//   dz_err  last completion was a divide by zero
//
// State table:
//   S_IDLE | waiting for start; single-cycle ops complete straight from here
//   S_ITER | MUL/DIV iterating, one multiplier/quotient bit per edge
module seq_alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               zero,
  output logic               carry,
  output logic               dz_err
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // MUL: {partial product high half, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               dz_q, dz_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic               a_lt_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] iter_next;

  always_comb begin
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = a - b;
    a_lt_b   = (a < b);

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole register right.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // Restoring divide: bring down the next dividend bit, subtract the
    // divisor, keep the difference only if it did not borrow.
    div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    if (div_diff[WIDTH])
      div_next = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

    iter_next = is_div_q ? div_next : mul_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b1;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          case (op)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum};
              carry_d  = add_sum[WIDTH];
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, sub_diff};
              carry_d  = a_lt_b;
            end
            OP_AND:  result_d = {{WIDTH{1'b0}}, a & b};
            OP_OR:   result_d = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  result_d = {{WIDTH{1'b0}}, a ^ b};
            OP_SLTU: result_d = {{(2*WIDTH-1){1'b0}}, a_lt_b};
            default: begin
              if (op == OP_DIV && b == '0) begin
                result_d = {a, {WIDTH{1'b1}}};
                dz_d     = 1'b1;
              end else begin
                // MUL or DIV: completion deferred to the last iteration edge
                done_d   = 1'b0;
                carry_d  = carry_q;
                dz_d     = dz_q;
                is_div_d = (op == OP_DIV);
                opnd_d   = (op == OP_DIV) ? b : a;
                work_d   = {{WIDTH{1'b0}}, (op == OP_DIV) ? a : b};
                cnt_d    = CNT_LOAD;
                busy_d   = 1'b1;
                state_d  = S_ITER;
              end
            end
          endcase
          if (done_d)
            zero_d = (result_d == '0);
        end
      end
      S_ITER: begin
        work_d = iter_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = iter_next;
          zero_d   = (iter_next == '0);
          carry_d  = 1'b0;
          dz_d     = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      dz_q     <= dz_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign dz_err = dz_q;

endmodule
